picorv32_mem_arbiter: RTL and testbench

Parametrised N-master round-robin arbiter for the PicoRV32 native memory bus (valid/instr/ready/addr/wdata/wstrb/rdata). Multiplexes NUM_MASTERS cores or DMA agents onto one native-bus memory port in picosoc-style systems, and routes each response back to the granted master. Successor to the single-channel bus definition: generalised in channel count and data width, with fairness, registered outputs and an optional hang watchdog.

---
 rtl/picorv32_mem_arbiter_if.sv | 31 +++
 rtl/picorv32_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_picorv32_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/picorv32_mem_arbiter_if.sv
// PicoRV32 native memory bus bundle.
// NUM_CH channels of valid/instr/addr/wdata/wstrb/ready with one shared rdata.
// The upstream side of the arbiter uses NUM_CH = NUM_MASTERS and the
// downstream side uses NUM_CH = 1.
interface picorv32_mem_arbiter_if #(
    parameter int NUM_CH     = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [NUM_CH-1:0]            mem_valid;
    logic [NUM_CH-1:0]            mem_instr;
    logic [NUM_CH*ADDR_WIDTH-1:0] mem_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] mem_wdata;
    logic [NUM_CH*STRB_W-1:0]     mem_wstrb;
    logic [NUM_CH-1:0]            mem_ready;
    logic [DATA_WIDTH-1:0]        mem_rdata;

    // Requester side: drives requests, receives completion and read data.
    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    // Responder side: receives requests, drives completion and read data.
    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picorv32_mem_arbiter.sv
// N-master round-robin arbiter for the PicoRV32 native memory bus.
// One transaction in flight: IDLE -> BUSY -> RESP -> IDLE, all outputs registered.
// Optional hang watchdog enabled by defining PICORV32_ARB_TIMEOUT_EN; without it
// timeout_err stays 0 and BUSY waits for the slave indefinitely.
module picorv32_mem_arbiter #(
    parameter int  NUM_MASTERS    = 2,
    parameter int  ADDR_WIDTH     = 32,
    parameter int  DATA_WIDTH     = 32,
    parameter int  TIMEOUT_CYCLES = 256,
    localparam int STRB_W         = DATA_WIDTH / 8,
    localparam int GNT_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    picorv32_mem_arbiter_if.slave  m_mem,
    picorv32_mem_arbiter_if.master s_mem,
    output logic [GNT_W-1:0]      grant_id,
    output logic                  timeout_err
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]             state_r;
    logic [GNT_W-1:0]       ptr_r;
    logic [GNT_W-1:0]       grant_r;
    logic                   s_valid_r;
    logic                   s_instr_r;
    logic [ADDR_WIDTH-1:0]  s_addr_r;
    logic [DATA_WIDTH-1:0]  s_wdata_r;
    logic [STRB_W-1:0]      s_wstrb_r;
    logic [NUM_MASTERS-1:0] m_ready_r;
    logic [DATA_WIDTH-1:0]  m_rdata_r;
    logic                   terr_r;

    logic [GNT_W:0]         cand_s;
    logic                   pick_found_s;
    logic [GNT_W-1:0]       pick_idx_s;
    logic [GNT_W-1:0]       ptr_next_s;
    logic                   sel_s;
    logic                   pick_instr_s;
    logic [ADDR_WIDTH-1:0]  pick_addr_s;
    logic [DATA_WIDTH-1:0]  pick_wdata_s;
    logic [STRB_W-1:0]      pick_wstrb_s;
    logic                   wd_expire_s;

    function automatic logic [NUM_MASTERS-1:0] grant_onehot(input logic [GNT_W-1:0] idx);
        logic [NUM_MASTERS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            v[i] = (idx == GNT_W'(i));
        end
        return v;
    endfunction

    // Round-robin search: first requester at or after ptr_r, wrapping. Scanning
    // from the far end lets the nearest candidate overwrite the others.
    always_comb begin
        cand_s       = '0;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            cand_s = {1'b0, ptr_r} + (GNT_W+1)'(i);
            if (cand_s >= (GNT_W+1)'(NUM_MASTERS)) begin
                cand_s = cand_s - (GNT_W+1)'(NUM_MASTERS);
            end else begin
                cand_s = cand_s;
            end
            if (m_mem.mem_valid[cand_s[GNT_W-1:0]]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s[GNT_W-1:0];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
        if (pick_idx_s == GNT_W'(NUM_MASTERS - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = pick_idx_s + GNT_W'(1);
        end
    end

    // AND-OR mux of the selected master's request fields.
    always_comb begin
        sel_s        = 1'b0;
        pick_instr_s = 1'b0;
        pick_addr_s  = '0;
        pick_wdata_s = '0;
        pick_wstrb_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            sel_s        = (pick_idx_s == GNT_W'(i));
            pick_instr_s = pick_instr_s | (m_mem.mem_instr[i] & sel_s);
            pick_addr_s  = pick_addr_s  | (m_mem.mem_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{sel_s}});
            pick_wdata_s = pick_wdata_s | (m_mem.mem_wdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_s}});
            pick_wstrb_s = pick_wstrb_s | (m_mem.mem_wstrb[i*STRB_W +: STRB_W] & {STRB_W{sel_s}});
        end
    end

`ifdef PICORV32_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_r;

    // Terminal count is the TIMEOUT_CYCLES-th BUSY cycle without a slave response.
    assign wd_expire_s = (state_r == ST_BUSY) && (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts BUSY cycles, clears whenever the FSM is anywhere else.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt_r <= '0;
        end else if ((state_r == ST_BUSY) && !s_mem.mem_ready[0] && !wd_expire_s) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_r <= '0;
        end
    end
`else
    // No watchdog: the abort path below reduces to constant zero.
    assign wd_expire_s = 1'b0;
`endif

    // Main FSM: grant, hold the downstream request, return a one-cycle response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            ptr_r     <= '0;
            grant_r   <= '0;
            s_valid_r <= 1'b0;
            s_instr_r <= 1'b0;
            s_addr_r  <= '0;
            s_wdata_r <= '0;
            s_wstrb_r <= '0;
            m_ready_r <= '0;
            m_rdata_r <= '0;
            terr_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        s_valid_r <= 1'b1;
                        s_instr_r <= pick_instr_s;
                        s_addr_r  <= pick_addr_s;
                        s_wdata_r <= pick_wdata_s;
                        s_wstrb_r <= pick_wstrb_s;
                        grant_r   <= pick_idx_s;
                        ptr_r     <= ptr_next_s;
                        state_r   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A response on the terminal-count cycle takes precedence.
                    if (s_mem.mem_ready[0]) begin
                        m_rdata_r <= s_mem.mem_rdata;
                        m_ready_r <= grant_onehot(grant_r);
                        s_valid_r <= 1'b0;
                        state_r   <= ST_RESP;
                    end else if (wd_expire_s) begin
                        m_rdata_r <= '0;
                        m_ready_r <= grant_onehot(grant_r);
                        terr_r    <= 1'b1;
                        s_valid_r <= 1'b0;
                        state_r   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    m_ready_r <= '0;
                    m_rdata_r <= '0;
                    terr_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    s_valid_r <= 1'b0;
                    m_ready_r <= '0;
                    m_rdata_r <= '0;
                    terr_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_mem.mem_valid[0] = s_valid_r;
    assign s_mem.mem_instr[0] = s_instr_r;
    assign s_mem.mem_addr     = s_addr_r;
    assign s_mem.mem_wdata    = s_wdata_r;
    assign s_mem.mem_wstrb    = s_wstrb_r;
    assign m_mem.mem_ready    = m_ready_r;
    assign m_mem.mem_rdata    = m_rdata_r;
    assign grant_id           = grant_r;
    assign timeout_err        = terr_r;
endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Scoreboard bench for picorv32_mem_arbiter with four masters.
// Stimulus pushes expected downstream requests and upstream responses into
// queues; two monitors pop and compare when the DUT presents them.
module tb_picorv32_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TC = 8;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic [3:0]  rdy;
        logic [31:0] rdata;
        logic        terr;
    } rsp_t;

    logic        clk;
    logic        resetn;
    logic [1:0]  grant_id;
    logic        timeout_err;

    int          n_checks = 0;
    int          n_pass   = 0;
    req_t        exp_req_q[$];
    rsp_t        exp_rsp_q[$];

    int          slave_wait  = 0;
    logic [31:0] slave_rdata = 32'h0;
    bit          echo        = 1'b0;
    bit          hang        = 1'b0;
    bit          force_ready = 1'b0;

    picorv32_mem_arbiter_if #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if();
    picorv32_mem_arbiter_if #(.NUM_CH(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if();

    picorv32_mem_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .resetn(resetn), .m_mem(m_if), .s_mem(s_if),
        .grant_id(grant_id), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL global_timeout: got no end, required end before 50000ns");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_master(input int i, input logic instr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb);
        m_if.mem_instr[i]         = instr;
        m_if.mem_addr[i*32 +: 32] = addr;
        m_if.mem_wdata[i*32 +: 32] = wdata;
        m_if.mem_wstrb[i*4 +: 4]  = wstrb;
    endtask

    task automatic push_req(input int i);
        req_t r;
        r.gnt   = 2'(i);
        r.instr = m_if.mem_instr[i];
        r.addr  = m_if.mem_addr[i*32 +: 32];
        r.wdata = m_if.mem_wdata[i*32 +: 32];
        r.wstrb = m_if.mem_wstrb[i*4 +: 4];
        exp_req_q.push_back(r);
    endtask

    task automatic push_rsp(input int i, input logic [31:0] rdata, input logic terr);
        rsp_t r;
        r.rdy   = 4'b0001 << i;
        r.rdata = rdata;
        r.terr  = terr;
        exp_rsp_q.push_back(r);
    endtask

    // Wait for n responses; masters drop valid on their ready unless keep is set.
    task automatic serve(input int n, input bit keep);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (m_if.mem_ready != 4'b0000) begin
                got++;
                if (!keep) m_if.mem_valid = m_if.mem_valid & ~m_if.mem_ready;
            end
        end
        check("serve_count", 64'(got), 64'(n));
    endtask

    task automatic wait_svalid();
        int cyc = 0;
        while (!s_if.mem_valid[0] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("svalid_seen", 64'(s_if.mem_valid[0]), 64'd1);
    endtask

    // Slave model: fixed wait count, one-cycle ready pulse, optional hang or forced ready.
    initial begin
        int wcnt = 0;
        s_if.mem_ready = 1'b0;
        s_if.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (force_ready) begin
                s_if.mem_ready = 1'b1;
            end else if (s_if.mem_ready[0]) begin
                s_if.mem_ready = 1'b0;
            end else if (s_if.mem_valid[0] && !hang) begin
                if (wcnt >= slave_wait) begin
                    s_if.mem_ready = 1'b1;
                    s_if.mem_rdata = echo ? ~s_if.mem_addr : slave_rdata;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Request monitor: each new downstream request is matched against the queue.
    initial begin
        logic prev = 1'b0;
        req_t e;
        forever begin
            @(negedge clk);
            if (s_if.mem_valid[0] && !prev) begin
                check("req_pending", 64'(exp_req_q.size() != 0), 64'd1);
                if (exp_req_q.size() != 0) begin
                    e = exp_req_q.pop_front();
                    check("req_grant", 64'(grant_id), 64'(e.gnt));
                    check("req_instr", 64'(s_if.mem_instr[0]), 64'(e.instr));
                    check("req_addr",  64'(s_if.mem_addr), 64'(e.addr));
                    check("req_wdata", 64'(s_if.mem_wdata), 64'(e.wdata));
                    check("req_wstrb", 64'(s_if.mem_wstrb), 64'(e.wstrb));
                end
            end
            prev = s_if.mem_valid[0];
        end
    end

    // Response monitor: ready cycles pop the queue, other cycles must show zeros.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (m_if.mem_ready != 4'b0000) begin
                check("rsp_pending", 64'(exp_rsp_q.size() != 0), 64'd1);
                if (exp_rsp_q.size() != 0) begin
                    e = exp_rsp_q.pop_front();
                    check("rsp_ready", 64'(m_if.mem_ready), 64'(e.rdy));
                    check("rsp_rdata", 64'(m_if.mem_rdata), 64'(e.rdata));
                    check("rsp_terr",  64'(timeout_err), 64'(e.terr));
                end
            end else begin
                check("idle_rdata_terr", {31'h0, timeout_err, m_if.mem_rdata}, 64'h0);
            end
        end
    end

    initial begin
        resetn = 1'b0;
        m_if.mem_valid = '0;
        m_if.mem_instr = '0;
        m_if.mem_addr  = '0;
        m_if.mem_wdata = '0;
        m_if.mem_wstrb = '0;
        repeat (2) @(negedge clk);
        check("rst_svalid", 64'(s_if.mem_valid), 64'd0);
        check("rst_grant",  64'(grant_id), 64'd0);
        check("rst_ready",  64'(m_if.mem_ready), 64'd0);
        check("rst_saddr",  64'(s_if.mem_addr), 64'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Contention: all four request continuously, zero-wait slave.
        echo = 1'b1;
        slave_wait = 0;
        for (int i = 0; i < N; i++) begin
            set_master(i, (i == 3), 32'h100 * (i + 1), 32'hA000_0000 + i, (i == 2) ? 4'hF : 4'h0);
        end
        for (int k = 0; k < 5; k++) begin
            push_req(k % N);
            push_rsp(k % N, ~(32'h100 * ((k % N) + 1)), 1'b0);
        end
        m_if.mem_valid = 4'b1111;
        serve(5, 1'b1);
        m_if.mem_valid = 4'b0000;
        repeat (3) @(negedge clk);

        // Single read with two slave wait cycles, checked at exact latencies.
        echo = 1'b0;
        slave_wait = 2;
        slave_rdata = 32'hCAFE_BABE;
        set_master(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        push_req(0);
        push_rsp(0, 32'hCAFE_BABE, 1'b0);
        m_if.mem_valid[0] = 1'b1;
        @(negedge clk);
        check("lat_svalid", 64'(s_if.mem_valid), 64'd1);
        check("lat_saddr",  64'(s_if.mem_addr), 64'h1000);
        repeat (3) @(negedge clk);
        check("lat_mready", 64'(m_if.mem_ready), 64'h1);
        m_if.mem_valid[0] = 1'b0;
        @(negedge clk);
        check("rsp_one_cycle", 64'(m_if.mem_ready), 64'h0);
        repeat (2) @(negedge clk);
        check("grant_hold0", 64'(grant_id), 64'd0);

        // Write from master 1, five wait cycles, request must stay stable.
        slave_wait = 5;
        slave_rdata = 32'h0BAD_F00D;
        set_master(1, 1'b0, 32'h0000_2004, 32'h1234_5678, 4'b0110);
        push_req(1);
        push_rsp(1, 32'h0BAD_F00D, 1'b0);
        m_if.mem_valid[1] = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("wr_hold_valid", 64'(s_if.mem_valid), 64'd1);
            check("wr_hold_wdata", 64'(s_if.mem_wdata), 64'h1234_5678);
            check("wr_hold_wstrb", 64'(s_if.mem_wstrb), 64'h6);
            check("wr_wait_rdata", 64'(m_if.mem_rdata), 64'h0);
        end
        serve(1, 1'b0);
        repeat (2) @(negedge clk);

        // Slave ready held high with no request: nothing may happen.
        force_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stray_ready", 64'(m_if.mem_ready), 64'h0);
            check("stray_svalid", 64'(s_if.mem_valid), 64'h0);
            check("grant_hold1", 64'(grant_id), 64'd1);
        end
        force_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in BUSY cycle 3 with master 0 granted; afterwards master 0 wins again.
        echo = 1'b1;
        slave_wait = 0;
        hang = 1'b1;
        set_master(0, 1'b0, 32'h0000_3000, 32'h5555_AAAA, 4'h3);
        push_req(0);
        m_if.mem_valid[0] = 1'b1;
        @(negedge clk);
        wait_svalid();
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("arst_svalid", 64'(s_if.mem_valid), 64'd0);
        check("arst_saddr",  64'(s_if.mem_addr), 64'd0);
        check("arst_wdata",  64'(s_if.mem_wdata), 64'd0);
        check("arst_ready",  64'(m_if.mem_ready), 64'd0);
        m_if.mem_valid = 4'b0000;
        hang = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        set_master(1, 1'b1, 32'h0000_4000, 32'h0, 4'h0);
        push_req(0);
        push_rsp(0, ~32'h0000_3000, 1'b0);
        push_req(1);
        push_rsp(1, ~32'h0000_4000, 1'b0);
        m_if.mem_valid = 4'b0011;
        serve(2, 1'b0);
        repeat (2) @(negedge clk);

        // Slave never answers.
        hang = 1'b1;
        set_master(2, 1'b0, 32'h0000_5000, 32'h0, 4'h0);
        push_req(2);
`ifdef PICORV32_ARB_TIMEOUT_EN
        push_rsp(2, 32'h0, 1'b1);
`endif
        m_if.mem_valid[2] = 1'b1;
        @(negedge clk);
        wait_svalid();
`ifdef PICORV32_ARB_TIMEOUT_EN
        serve(1, 1'b0);
        check("to_svalid", 64'(s_if.mem_valid), 64'd0);
        hang = 1'b0;
`else
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("hang_svalid", 64'(s_if.mem_valid), 64'd1);
            check("hang_terr", 64'(timeout_err), 64'd0);
        end
        resetn = 1'b0;
        m_if.mem_valid = 4'b0000;
        hang = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check("req_q_empty", 64'(exp_req_q.size()), 64'd0);
        check("rsp_q_empty", 64'(exp_rsp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
